ps2_encoder: RTL



---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_quarter_timer.sv | 41 ++++
 rtl/ps2_encoder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by both the transmit (encoder) and receive (decoder) paths.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } ps2_state_t;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Parity bit that makes the total number of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_quarter_timer.sv
// Quarter bit-period pacer: tick is high on the last clk cycle of every quarter while run is high.
module ps2_quarter_timer #(
    parameter int QUARTER_CYCLES = 1250
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int             CNT_W = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(QUARTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             tick_r;

    // Next count value, wrapping at the terminal count.
    always_comb begin
        cnt_nxt_s = '0;
        if (cnt_r == LAST) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter and look-ahead tick register; the first cycle after run rises is count 0, never a tick.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/ps2_encoder.sv
// PS/2 device-side transmitter: sends each accepted byte as an 11-bit frame followed by an idle gap.
module ps2_encoder
    import ps2_pkg::*;
#(
    parameter int QUARTER_CYCLES = 1250,
    parameter int GAP_CYCLES     = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    input  logic       inhibit,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

    ps2_state_t            state_r;
    logic [FRAME_BITS-1:0] frame_r;
    logic [3:0]            bit_idx_r;
    logic [1:0]            quarter_r;
    logic [GAP_W-1:0]      gap_cnt_r;
    logic                  killed_r;
    logic                  ps2_clk_r;
    logic                  ps2_data_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  aborted_r;
    logic                  tick_s;
    logic                  run_s;
    logic                  ready_s;

    assign ready_s = (state_r == IDLE) & ~inhibit & ~rst;
    assign run_s   = (state_r == FRAME);

    ps2_quarter_timer #(
        .QUARTER_CYCLES(QUARTER_CYCLES)
    ) u_quarter_timer (
        .clk (clk),
        .rst (rst),
        .run (run_s),
        .tick(tick_s)
    );

    // Frame FSM: all line and status outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            frame_r    <= '0;
            bit_idx_r  <= 4'd0;
            quarter_r  <= 2'd0;
            gap_cnt_r  <= '0;
            killed_r   <= 1'b0;
            ps2_clk_r  <= 1'b1;
            ps2_data_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            aborted_r  <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (valid && ready_s) begin
                        frame_r    <= {STOP_BIT, odd_parity(data_in), data_in, START_BIT};
                        state_r    <= FRAME;
                        bit_idx_r  <= 4'd0;
                        quarter_r  <= 2'd0;
                        killed_r   <= 1'b0;
                        ps2_clk_r  <= 1'b1;
                        ps2_data_r <= START_BIT;
                        busy_r     <= 1'b1;
                    end
                end
                FRAME: begin
                    if (inhibit) begin
                        // Host pulled the clock low: release both lines and drop the byte.
                        state_r    <= GAP;
                        gap_cnt_r  <= '0;
                        killed_r   <= 1'b1;
                        ps2_clk_r  <= 1'b1;
                        ps2_data_r <= 1'b1;
                        aborted_r  <= 1'b1;
                    end else if (tick_s) begin
                        if (quarter_r == 2'd3) begin
                            if (bit_idx_r == LAST_BIT) begin
                                state_r    <= GAP;
                                gap_cnt_r  <= '0;
                                ps2_clk_r  <= 1'b1;
                                ps2_data_r <= 1'b1;
                            end else begin
                                bit_idx_r  <= bit_idx_r + 4'd1;
                                quarter_r  <= 2'd0;
                                ps2_clk_r  <= 1'b1;
                                ps2_data_r <= frame_r[bit_idx_r + 4'd1];
                            end
                        end else begin
                            // Clock is low during the middle two quarters of each bit.
                            quarter_r <= quarter_r + 2'd1;
                            ps2_clk_r <= (quarter_r == 2'd0) || (quarter_r == 2'd1) ? 1'b0 : 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= ~killed_r;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    ps2_clk_r  <= 1'b1;
                    ps2_data_r <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign ready    = ready_s;
    assign ps2_clk  = ps2_clk_r;
    assign ps2_data = ps2_data_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign aborted  = aborted_r;

endmodule
